// File: rtl/wavelet_block_processor_p_pkg.sv
// Shared types and default sizing for the wavelet block processor.
package wavelet_block_processor_p_pkg;

  localparam int unsigned W_DEF      = 8;
  localparam int unsigned LENGTH_DEF = 16;

  typedef enum logic [1:0] {
    EDGE_INTERIOR = 2'd0,
    EDGE_TOP      = 2'd1,
    EDGE_BOTTOM   = 2'd2,
    EDGE_RSVD     = 2'd3
  } edge_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROW_PROC = 2'd1,
    ST_COL_PROC = 2'd2
  } state_t;

endpackage

// File: rtl/wavelet_block_processor_p_if.sv
// Coefficient-pair output stream with valid/ready backpressure.
interface wavelet_block_processor_p_if #(
  parameter int unsigned CW = 10,
  parameter int unsigned IW = 4
);
  logic                 out_valid;
  logic                 out_ready;
  logic signed [CW-1:0] out_s;
  logic signed [CW-1:0] out_d;
  logic [IW-1:0]        out_idx;

  modport master (output out_valid, out_s, out_d, out_idx, input out_ready);
  modport slave  (input out_valid, out_s, out_d, out_idx, output out_ready);
endinterface

// File: rtl/wavelet_block_processor_p_haar.sv
// Combinational integer Haar lift of one sample pair: L = floor mean, H = difference.
module haar_pair_lift #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]        x0_i,
  input  logic [W-1:0]        x1_i,
  output logic [W-1:0]        l_c_o,
  output logic signed [W:0]   h_c_o
);
  localparam int unsigned W1 = W + 1;

  logic [W:0] sum_c;

  assign sum_c = W1'(x0_i) + W1'(x1_i);
  assign l_c_o = W'(sum_c >> 1);
  assign h_c_o = signed'(W1'(x0_i) - W1'(x1_i));
endmodule

// File: rtl/wavelet_block_processor_p.sv
// Three-row window capture, per-row Haar lifting, then three-tap column lifting on the
// middle row streamed as (s, d) pairs.
module wavelet_block_processor_p
  import wavelet_block_processor_p_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned LENGTH = LENGTH_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [1:0]               edge_mode,
  input  logic [LENGTH-1:0][W-1:0] in_row_0,
  input  logic [LENGTH-1:0][W-1:0] in_row_1,
  input  logic [LENGTH-1:0][W-1:0] in_row_2,
  output logic                     busy,
  output logic                     done,
  wavelet_block_processor_p_if.master out_if
);
  localparam int unsigned CW   = W + 2;
  localparam int unsigned CW1  = CW + 1;
  localparam int unsigned HALF = LENGTH / 2;
  localparam int unsigned IW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned KW   = (HALF > 1) ? $clog2(HALF) : 1;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 valid_q, valid_d;
  logic signed [CW-1:0] s_q, s_d, d_q, d_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 capture_c, row_we_c;

  edge_mode_t           edge_q;
  logic [W-1:0]         row_q  [3][LENGTH];
  logic signed [CW-1:0] coef_q [3][LENGTH];

  logic [W-1:0]         lift_l_c [3];
  logic signed [W:0]    lift_h_c [3];
  logic [IW-1:0]        lo_idx_c, hi_idx_c, h_idx_c, j_c;
  logic signed [CW:0]   c0_c, c1_c, c2_c, p_c, dw_c, sw_c;

  assign lo_idx_c = IW'({k_q, 1'b0});
  assign hi_idx_c = lo_idx_c | IW'(1);
  assign h_idx_c  = IW'(HALF) + IW'(k_q);

  for (genvar r = 0; r < 3; r++) begin : g_lift
    haar_pair_lift #(.W(W)) u_lift (
      .x0_i  (row_q[r][lo_idx_c]),
      .x1_i  (row_q[r][hi_idx_c]),
      .l_c_o (lift_l_c[r]),
      .h_c_o (lift_h_c[r])
    );
  end

  // Window and coefficient storage: capture on accept, fill one pair per ROW cycle.
  always_ff @(posedge clk or negedge resetn) begin : p_data
    if (!resetn) begin
      edge_q <= EDGE_INTERIOR;
      for (int r = 0; r < 3; r++) begin
        for (int i = 0; i < int'(LENGTH); i++) begin
          row_q[r][i]  <= '0;
          coef_q[r][i] <= '0;
        end
      end
    end else if (capture_c) begin
      edge_q <= edge_mode_t'(edge_mode);
      for (int i = 0; i < int'(LENGTH); i++) begin
        row_q[0][i] <= in_row_0[i];
        row_q[1][i] <= in_row_1[i];
        row_q[2][i] <= in_row_2[i];
      end
    end else if (row_we_c) begin
      for (int r = 0; r < 3; r++) begin
        coef_q[r][IW'(k_q)] <= CW'(lift_l_c[r]);
        coef_q[r][h_idx_c]  <= CW'(lift_h_c[r]);
      end
    end
  end

  // Column lift for the next position; edge rows mirrored at read time.
  always_comb begin : p_col
    j_c  = valid_q ? idx_q + IW'(1) : '0;
    c0_c = CW1'(coef_q[0][j_c]);
    c1_c = CW1'(coef_q[1][j_c]);
    c2_c = CW1'(coef_q[2][j_c]);
    if (edge_q == EDGE_TOP) begin
      c0_c = c2_c;
    end else if (edge_q == EDGE_BOTTOM) begin
      c2_c = c0_c;
    end
    p_c  = (c0_c + c2_c) >>> 1;
    dw_c = c1_c - p_c;
    sw_c = c1_c + (dw_c >>> 1);
  end

  always_comb begin : p_fsm
    state_d   = state_q;
    k_d       = k_q;
    valid_d   = valid_q;
    s_d       = s_q;
    d_d       = d_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    capture_c = 1'b0;
    row_we_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture_c = 1'b1;
          k_d       = '0;
          state_d   = ST_ROW_PROC;
        end
      end
      ST_ROW_PROC: begin
        row_we_c = 1'b1;
        k_d      = k_q + KW'(1);
        if (k_q == KW'(HALF - 1)) begin
          k_d     = '0;
          state_d = ST_COL_PROC;
        end
      end
      ST_COL_PROC: begin
        // Advance only when nothing is presented or the presented pair is taken.
        if (!valid_q || out_if.out_ready) begin
          if (valid_q && (idx_q == IW'(LENGTH - 1))) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            valid_d = 1'b1;
            s_d     = CW'(sw_c);
            d_d     = CW'(dw_c);
            idx_d   = j_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin : p_state
    if (!resetn) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      valid_q <= 1'b0;
      s_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      s_q     <= s_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_s     = s_q;
  assign out_if.out_d     = d_q;
  assign out_if.out_idx   = idx_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_wavelet_block_processor_p.sv
// Self-checking bench for wavelet_block_processor_p (W=8, LENGTH=4).
module tb_wavelet_block_processor_p;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned IW = 2;

  logic                clk    = 1'b0;
  logic                resetn = 1'b0;
  logic                start  = 1'b0;
  logic [1:0]          edge_mode = '0;
  logic [N-1:0][W-1:0] in_row_0 = '0;
  logic [N-1:0][W-1:0] in_row_1 = '0;
  logic [N-1:0][W-1:0] in_row_2 = '0;
  logic                busy;
  logic                done;

  int total = 0;
  int bad   = 0;
  int row   [3][N];
  int exp_s [N];
  int exp_d [N];

  wavelet_block_processor_p_if #(.CW(CW), .IW(IW)) ifc ();

  wavelet_block_processor_p #(.W(W), .LENGTH(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .edge_mode (edge_mode),
    .in_row_0  (in_row_0),
    .in_row_1  (in_row_1),
    .in_row_2  (in_row_2),
    .busy      (busy),
    .done      (done),
    .out_if    (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv2(input int v);
    return (v >= 0) ? v / 2 : -((1 - v) / 2);
  endfunction

  // Reference: row Haar, [L.., H..] layout, edge mirroring, then column lifting.
  task automatic model(input int mode);
    int c [3][N];
    int p;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < int'(N / 2); k++) begin
        c[r][k]         = (row[r][2*k] + row[r][2*k+1]) / 2;
        c[r][N / 2 + k] = row[r][2*k] - row[r][2*k+1];
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (mode == 1) c[0][j] = c[2][j];
      if (mode == 2) c[2][j] = c[0][j];
      p        = fdiv2(c[0][j] + c[2][j]);
      exp_d[j] = c[1][j] - p;
      exp_s[j] = c[1][j] + fdiv2(exp_d[j]);
    end
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c, input int d);
    row[r][0] = a; row[r][1] = b; row[r][2] = c; row[r][3] = d;
  endtask

  task automatic random_rows();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < int'(N); i++) row[r][i] = int'($urandom_range(0, 255));
  endtask

  task automatic drive_rows();
    for (int i = 0; i < int'(N); i++) begin
      in_row_0[i] = 8'(row[0][i]);
      in_row_1[i] = 8'(row[1][i]);
      in_row_2[i] = 8'(row[2][i]);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < int'(N); i++) begin
      in_row_0[i] = 8'($urandom);
      in_row_1[i] = 8'($urandom);
      in_row_2[i] = 8'($urandom);
    end
    edge_mode = 2'($urandom);
  endtask

  task automatic run_block(input int mode, input int stall);
    int cyc;
    model(mode);
    drive_rows();
    edge_mode     = 2'(mode);
    start         = 1'b1;
    ifc.out_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    chk("busy_after_start", int'(busy), 1);
    cyc = 0;
    while (ifc.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("first_valid_latency", cyc, N / 2 + 1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", int'(ifc.out_valid), 1);
      chk("stall_idx", int'(ifc.out_idx), 0);
      chk("stall_s", int'(ifc.out_s), exp_s[0]);
      chk("stall_d", int'(ifc.out_d), exp_d[0]);
      chk("stall_no_done", int'(done), 0);
      start = 1'b1;
      @(posedge clk); #1;
    end
    start         = 1'b0;
    ifc.out_ready = 1'b1;
    for (int j = 0; j < int'(N); j++) begin
      chk("pair_valid", int'(ifc.out_valid), 1);
      chk("pair_idx", int'(ifc.out_idx), j);
      chk("pair_s", int'(ifc.out_s), exp_s[j]);
      chk("pair_d", int'(ifc.out_d), exp_d[j]);
      chk("pair_busy", int'(busy), 1);
      chk("pair_no_done", int'(done), 0);
      @(posedge clk); #1;
    end
    chk("done_pulse", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("valid_after_last", int'(ifc.out_valid), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  task automatic run_random(input int mode);
    int  nexp, guard, ps, pd, pidx;
    bit  pend;
    model(mode);
    drive_rows();
    edge_mode     = 2'(mode);
    start         = 1'b1;
    ifc.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    nexp = 0; guard = 0; pend = 1'b0;
    ps = 0; pd = 0; pidx = 0;
    while (nexp < int'(N) && guard < 200) begin
      if (pend) begin
        chk("hold_valid", int'(ifc.out_valid), 1);
        chk("hold_idx", int'(ifc.out_idx), pidx);
        chk("hold_s", int'(ifc.out_s), ps);
        chk("hold_d", int'(ifc.out_d), pd);
      end
      ifc.out_ready = 1'($urandom_range(0, 1));
      start         = 1'($urandom_range(0, 1));
      pend          = 1'b0;
      if (ifc.out_valid === 1'b1) begin
        if (ifc.out_ready) begin
          chk("rnd_idx", int'(ifc.out_idx), nexp);
          chk("rnd_s", int'(ifc.out_s), exp_s[nexp]);
          chk("rnd_d", int'(ifc.out_d), exp_d[nexp]);
          nexp++;
        end else begin
          pend = 1'b1;
          pidx = int'(ifc.out_idx);
          ps   = int'(ifc.out_s);
          pd   = int'(ifc.out_d);
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    chk("rnd_block_complete", nexp, N);
    chk("rnd_done", int'(done), 1);
    chk("rnd_busy_at_done", int'(busy), 0);
  endtask

  initial begin
    int guard;
    ifc.out_ready = 1'b1;
    #1;
    chk("rst_valid", int'(ifc.out_valid), 0);
    chk("rst_s", int'(ifc.out_s), 0);
    chk("rst_d", int'(ifc.out_d), 0);
    chk("rst_idx", int'(ifc.out_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // Constant rows.
    for (int r = 0; r < 3; r++) set_row(r, 100, 100, 100, 100);
    run_block(0, 0);
    // Ramp on the target row only.
    set_row(0, 0, 0, 0, 0); set_row(1, 10, 20, 30, 40); set_row(2, 0, 0, 0, 0);
    run_block(0, 0);
    chk("ramp_s0_const", exp_s[0], 22);
    // Top edge: row 0 must be ignored.
    set_row(0, 255, 255, 255, 255); set_row(1, 0, 0, 0, 0); set_row(2, 200, 200, 200, 200);
    run_block(1, 0);
    // Extremes.
    set_row(0, 0, 255, 0, 255); set_row(1, 255, 0, 255, 0); set_row(2, 0, 255, 0, 255);
    run_block(0, 0);
    // Bottom edge with random data.
    random_rows();
    run_block(2, 0);
    // Backpressure at first valid, with start pulses while busy.
    random_rows();
    run_block(int'($urandom_range(0, 3)), 3);

    for (int b = 0; b < 6; b++) begin
      random_rows();
      run_random(int'($urandom_range(0, 3)));
    end

    // Abort mid-COL.
    random_rows();
    model(0);
    drive_rows();
    edge_mode     = 2'd0;
    ifc.out_ready = 1'b1;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (ifc.out_valid !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    chk("abort_at_idx1", int'(ifc.out_idx), 1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_valid", int'(ifc.out_valid), 0);
    chk("abort_s", int'(ifc.out_s), 0);
    chk("abort_d", int'(ifc.out_d), 0);
    chk("abort_idx", int'(ifc.out_idx), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_abort_idle_valid", int'(ifc.out_valid), 0);
      chk("post_abort_idle_busy", int'(busy), 0);
    end
    random_rows();
    run_block(int'($urandom_range(0, 3)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
